// File: rtl/program_sequencer_pkg.sv
// Shared types and defaults for the program sequencer front end.
package program_sequencer_pkg;

  localparam int PROG_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_LOAD = 2'd1,
    SEQ_RUN  = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/program_sequencer_mem.sv
// Program word store: one write port, two combinational read ports.
module program_mem
  import program_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = PROG_DEPTH_DEFAULT,
  parameter int PC_W       = $clog2(PROG_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  logic [2:0]      wdata,
  input  logic [PC_W-1:0] raddr0,
  input  logic [PC_W-1:0] raddr1,
  output logic [2:0]      rdata0,
  output logic [2:0]      rdata1
);

  localparam int AW = $clog2(PROG_DEPTH);

  logic [2:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < PC_W'(PROG_DEPTH))) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // Addresses past the store read as zero so pc+1 never indexes off the end.
  always_comb begin
    rdata0 = (raddr0 < PC_W'(PROG_DEPTH)) ? mem[raddr0[AW-1:0]] : 3'd0;
    rdata1 = (raddr1 < PC_W'(PROG_DEPTH)) ? mem[raddr1[AW-1:0]] : 3'd0;
  end

endmodule

// File: rtl/program_sequencer.sv
// Front-end controller: program load, fetch of opcode/operand pairs,
// per-stage valid tracking, JNZ redirect and completion detection.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = PROG_DEPTH_DEFAULT,
  parameter int PC_W       = $clog2(PROG_DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [2:0] load_data,
  input  logic       load_end,
  input  logic       start,
  input  logic       stall_in,
  input  logic       jump_taken,
  input  logic [2:0] jump_target,
  output logic [2:0] opcode,
  output logic [2:0] operand,
  output logic       f_valid,
  output logic       id_valid,
  output logic       ex_valid,
  output logic       halt_id,
  output logic       busy,
  output logic       done
);

  seq_state_t      state, state_n;
  logic [PC_W-1:0] pc, pc_n, prog_len, prog_len_n, pc_plus1;
  logic [2:0]      opcode_n, operand_n, rd0, rd1;
  logic            f_n, id_n, ex_n, busy_n, done_n;
  logic            mem_we, can_fetch, store_full;

  program_mem #(
    .PROG_DEPTH(PROG_DEPTH),
    .PC_W      (PC_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_len),
    .wdata (load_data),
    .raddr0(pc),
    .raddr1(pc_plus1),
    .rdata0(rd0),
    .rdata1(rd1)
  );

  assign pc_plus1   = pc + PC_W'(1);
  assign can_fetch  = pc_plus1 < prog_len;
  assign store_full = prog_len == PC_W'(PROG_DEPTH);
  assign halt_id    = stall_in | (state != SEQ_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEQ_IDLE;
      pc       <= '0;
      prog_len <= '0;
      opcode   <= 3'd0;
      operand  <= 3'd0;
      f_valid  <= 1'b0;
      id_valid <= 1'b0;
      ex_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      prog_len <= prog_len_n;
      opcode   <= opcode_n;
      operand  <= operand_n;
      f_valid  <= f_n;
      id_valid <= id_n;
      ex_valid <= ex_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    prog_len_n = prog_len;
    opcode_n   = opcode;
    operand_n  = operand;
    f_n        = f_valid;
    id_n       = id_valid;
    ex_n       = ex_valid;
    mem_we     = 1'b0;

    case (state)
      SEQ_IDLE, SEQ_DONE: begin
        if (load_start) begin
          state_n    = SEQ_LOAD;
          prog_len_n = '0;
        end else if (start) begin
          state_n = SEQ_RUN;
          pc_n    = '0;
        end
      end

      SEQ_LOAD: begin
        if (load_valid && !store_full) begin
          mem_we     = 1'b1;
          prog_len_n = prog_len + PC_W'(1);
        end
        if (load_end) begin
          state_n = SEQ_IDLE;
        end
      end

      SEQ_RUN: begin
        if (!stall_in) begin
          if (jump_taken) begin
            pc_n = PC_W'(jump_target);
            f_n  = 1'b0;
            id_n = 1'b0;
            ex_n = 1'b0;
          end else begin
            if (can_fetch) begin
              opcode_n  = rd0;
              operand_n = rd1;
              f_n       = 1'b1;
              pc_n      = pc + PC_W'(2);
            end else begin
              f_n = 1'b0;
            end
            id_n = f_valid;
            ex_n = id_valid;
            // Finish on the edge that leaves all three stages empty.
            if (!can_fetch && !f_valid && !id_valid) begin
              state_n = SEQ_DONE;
            end
          end
        end
      end

      default: state_n = SEQ_IDLE;
    endcase

    busy_n = (state_n == SEQ_LOAD) || (state_n == SEQ_RUN);
    done_n = (state_n == SEQ_DONE);
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: per-cycle vector tables plus
// hand-written overflow and asynchronous-reset sequences.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0, load_valid = 1'b0, load_end = 1'b0;
  logic [2:0] load_data = 3'd0;
  logic       start = 1'b0, stall_in = 1'b0, jump_taken = 1'b0;
  logic [2:0] jump_target = 3'd0;
  logic [2:0] opcode, operand;
  logic       f_valid, id_valid, ex_valid, halt_id, busy, done;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct packed {
    logic       ls, lv;
    logic [2:0] ld;
    logic       le, st, stl, jt;
    logic [2:0] tgt;
    logic [2:0] e_opc, e_opr;
    logic       e_f, e_id, e_ex, e_halt, e_busy, e_done;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] prog_q[$];

  program_sequencer #(.PROG_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_end(load_end),
    .start(start), .stall_in(stall_in), .jump_taken(jump_taken), .jump_target(jump_target),
    .opcode(opcode), .operand(operand),
    .f_valid(f_valid), .id_valid(id_valid), .ex_valid(ex_valid),
    .halt_id(halt_id), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(int ls, int lv, int ld, int le, int st, int stl, int jt, int tgt,
                               int opc, int opr, int f, int id, int ex, int halt, int bsy, int dn);
    vec_t v;
    v.ls = 1'(ls); v.lv = 1'(lv); v.ld = 3'(ld); v.le = 1'(le);
    v.st = 1'(st); v.stl = 1'(stl); v.jt = 1'(jt); v.tgt = 3'(tgt);
    v.e_opc = 3'(opc); v.e_opr = 3'(opr);
    v.e_f = 1'(f); v.e_id = 1'(id); v.e_ex = 1'(ex);
    v.e_halt = 1'(halt); v.e_busy = 1'(bsy); v.e_done = 1'(dn);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] opc, input logic [2:0] opr,
                          input logic f, input logic id, input logic ex,
                          input logic halt, input logic bsy, input logic dn);
    checkOutput({tag, ".opcode"},   opcode,   opc);
    checkOutput({tag, ".operand"},  operand,  opr);
    checkOutput({tag, ".f_valid"},  f_valid,  f);
    checkOutput({tag, ".id_valid"}, id_valid, id);
    checkOutput({tag, ".ex_valid"}, ex_valid, ex);
    checkOutput({tag, ".halt_id"},  halt_id,  halt);
    checkOutput({tag, ".busy"},     busy,     bsy);
    checkOutput({tag, ".done"},     done,     dn);
  endtask

  task automatic applyStimulus(input vec_t v);
    load_start = v.ls; load_valid = v.lv; load_data = v.ld; load_end = v.le;
    start = v.st; stall_in = v.stl; jump_taken = v.jt; jump_target = v.tgt;
  endtask

  task automatic clearInputs();
    load_start = 0; load_valid = 0; load_data = 0; load_end = 0;
    start = 0; stall_in = 0; jump_taken = 0; jump_target = 0;
  endtask

  task automatic runVectors(input int scen);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkAll($sformatf("s%0d.r%0d", scen, i), vecs[i].e_opc, vecs[i].e_opr, vecs[i].e_f,
               vecs[i].e_id, vecs[i].e_ex, vecs[i].e_halt, vecs[i].e_busy, vecs[i].e_done);
    end
    clearInputs();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic loadProgram();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < prog_q.size(); i++) begin
      load_valid = 1'b1;
      load_data  = prog_q[i];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_end   = 1'b1;
    @(posedge clk); #1;
    load_end = 1'b0;
  endtask

  initial begin
    // Reset values before any clock edge.
    #2;
    checkAll("reset", 3'd0, 3'd0, 0, 0, 0, 1, 0, 0);
    #1;

    // Straight-line 4-word program.
    applyReset();
    prog_q = '{3'd0, 3'd3, 3'd5, 3'd4};
    loadProgram();
    vecs = {};
    vecs.push_back(row(0,0,0,0, 1,0,0,0, 0,0, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 0,3, 1,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 5,4, 1,1,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 5,4, 0,1,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 5,4, 0,0,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 5,4, 0,0,0, 1,0,1));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 5,4, 0,0,0, 1,0,1));
    runVectors(1);

    // Taken jumps: back to 0 mid-drain, then to 2 just as DONE would be reached.
    applyReset();
    prog_q = '{3'd5, 3'd4, 3'd3, 3'd0};
    loadProgram();
    vecs = {};
    vecs.push_back(row(0,0,0,0, 1,0,0,0, 0,0, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 5,4, 1,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 1,1,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 0,1,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,1,0, 3,0, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 5,4, 1,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 1,1,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 0,1,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 0,0,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,1,2, 3,0, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 1,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 0,1,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 0,0,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 3,0, 0,0,0, 1,0,1));
    runVectors(2);

    // Three-cycle stall with a jump presented during the stall.
    applyReset();
    prog_q = '{3'd0, 3'd3, 3'd5, 3'd4, 3'd2, 3'd6};
    loadProgram();
    vecs = {};
    vecs.push_back(row(0,0,0,0, 1,0,0,0, 0,0, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 0,3, 1,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,1,0,0, 0,3, 1,0,0, 1,1,0));
    vecs.push_back(row(0,0,0,0, 0,1,1,4, 0,3, 1,0,0, 1,1,0));
    vecs.push_back(row(0,0,0,0, 0,1,0,0, 0,3, 1,0,0, 1,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 5,4, 1,1,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 2,6, 1,1,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 2,6, 0,1,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 2,6, 0,0,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 2,6, 0,0,0, 1,0,1));
    runVectors(3);

    // Odd length, restart from DONE, and a jump past the end of the program.
    applyReset();
    prog_q = '{3'd1, 3'd2, 3'd7};
    loadProgram();
    vecs = {};
    vecs.push_back(row(0,0,0,0, 1,0,0,0, 0,0, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 1,2, 1,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 1,2, 0,1,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 1,2, 0,0,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 1,2, 0,0,0, 1,0,1));
    vecs.push_back(row(0,0,0,0, 1,0,0,0, 1,2, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 1,2, 1,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,1,7, 1,2, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 1,2, 0,0,0, 1,0,1));
    runVectors(4);

    // Empty program, load_start beating start, and a word written with load_end.
    applyReset();
    vecs = {};
    vecs.push_back(row(0,0,0,0, 1,0,0,0, 0,0, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 0,0, 0,0,0, 1,0,1));
    vecs.push_back(row(1,0,0,0, 1,0,0,0, 0,0, 0,0,0, 1,1,0));
    vecs.push_back(row(0,1,6,0, 0,0,0,0, 0,0, 0,0,0, 1,1,0));
    vecs.push_back(row(0,1,1,1, 0,0,0,0, 0,0, 0,0,0, 1,0,0));
    vecs.push_back(row(0,0,0,0, 1,0,0,0, 0,0, 0,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 6,1, 1,0,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 6,1, 0,1,0, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 6,1, 0,0,1, 0,1,0));
    vecs.push_back(row(0,0,0,0, 0,0,0,0, 6,1, 0,0,0, 1,0,1));
    runVectors(5);

    // Overflow: 20 words offered, only the first 16 are kept.
    applyReset();
    prog_q = {};
    for (int i = 0; i < 16; i++) prog_q.push_back(3'((i * 3 + 1) & 7));
    for (int i = 0; i < 4; i++) prog_q.push_back(3'd0);
    loadProgram();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("ovf.busy", busy, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("ovf.k%0d.opcode", k), opcode, prog_q[2*k]);
      checkOutput($sformatf("ovf.k%0d.operand", k), operand, prog_q[2*k+1]);
      checkOutput($sformatf("ovf.k%0d.f_valid", k), f_valid, 1'b1);
    end
    @(posedge clk); #1;
    checkOutput("ovf.end.f_valid", f_valid, 1'b0);
    @(posedge clk); #1;
    checkOutput("ovf.end.done_early", done, 1'b0);
    @(posedge clk); #1;
    checkOutput("ovf.end.done", done, 1'b1);

    // Asynchronous reset in the middle of a run, then start without reload.
    applyReset();
    prog_q = '{3'd0, 3'd3, 3'd5, 3'd4};
    loadProgram();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkAll("rstmid.before", 3'd5, 3'd4, 1, 1, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    checkAll("rstmid.async", 3'd0, 3'd0, 0, 0, 0, 1, 0, 0);
    #2;
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkAll("rstmid.run", 3'd0, 3'd0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    checkAll("rstmid.done", 3'd0, 3'd0, 0, 0, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Front-end controller for the 3-bit computer core. It holds the loaded program in a small word store and owns the program counter. It fetches opcode/operand pairs into the fetch register that feeds `instruction_decode` and drives that stage's `halt_id`. It also tracks per-stage valid bits, redirects fetch on a taken JNZ resolved in EX, and reports completion once the pipeline drains after the program counter leaves the program.

## Interface
Parameters:
- `PROG_DEPTH`, 16: number of 3-bit program words stored.
- `PC_W`, `$clog2(PROG_DEPTH)+1`: width of program counter and length register. Must be able to hold `PROG_DEPTH` itself.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  pulse: enter LOAD and clear program length.
- `load_valid`  in  1  qualifies `load_data` while in LOAD.
- `load_data`  in  3  program word.
- `load_end`  in  1  pulse: leave LOAD for IDLE.
- `start`  in  1  pulse: begin execution at word 0.
- `stall_in`  in  1  downstream backpressure (output buffer full); freezes the pipeline.
- `jump_taken`  in  1  EX stage resolved a taken JNZ this cycle.
- `jump_target`  in  3  literal operand of that JNZ (word address).
- `opcode`  out  3  fetched opcode to ID.
- `operand`  out  3  fetched operand to ID.
- `f_valid`, `id_valid`, `ex_valid`  out  1 each  stage valid bits; EX suppresses writes when `ex_valid`=0.
- `halt_id`  out  1  hold for ID stage registers.
- `busy`  out  1  state is LOAD or RUN.
- `done`  out  1  level, high in DONE.

Reset values: state IDLE, `pc`=0, `prog_len`=0, `opcode`=`operand`=0, all valids 0, `halt_id`=1, `busy`=0, `done`=0. Store contents are not reset.

## Operation
States are IDLE, LOAD, RUN and DONE.

- **IDLE/DONE**
  - `load_start` → LOAD, `prog_len`←0.
  - Else `start` → RUN, `pc`←0.
  - `load_start` wins over a simultaneous `start`.
  - DONE holds `done`=1 until it leaves.
- **LOAD**
  - Each `load_valid` cycle writes `mem[prog_len]`←`load_data` and `prog_len`++.
  - Writes with `prog_len`==`PROG_DEPTH` are dropped.
  - `load_end` → IDLE. A word presented with `load_end` in the same cycle is still written.
- **RUN**, each cycle with `stall_in`=0:
  - Fetch when `pc+1 < prog_len`: `opcode`←`mem[pc]`, `operand`←`mem[pc+1]`, `f_valid`←1, `pc`←`pc+2`.
  - Otherwise (end of program, including an odd trailing word): `f_valid`←0 and `pc` holds.
  - Shift valids: `id_valid`←`f_valid`, `ex_valid`←`id_valid`.
  - On `jump_taken`:
    - `pc`←`jump_target` (zero-extended).
    - `f_valid`, `id_valid` and `ex_valid` are all cleared; no fetch this cycle.
    - The redirect takes priority over the normal fetch and shift.
    - A target with `target+1 >= prog_len` leads straight to end-of-program.
  - Completion: fetch at end of program, all three valids 0, and no `jump_taken` → DONE.
- **Stall in RUN** (`stall_in`=1): `pc`, fetch registers and valids all hold, `jump_taken` is ignored, and `halt_id`=1.
- `halt_id` = `stall_in` OR (state ≠ RUN).
- `rst` mid-operation returns everything to reset values immediately; the program must be reloaded.

## Timing
- `start` at cycle t: RUN from t+1. First fetch edge is t+1, so `opcode`/`operand`/`f_valid` are valid after that edge, `id_valid` one cycle later, `ex_valid` two cycles later.
- Throughput is one instruction per unstalled cycle.
- Taken JNZ at cycle t: target fetched at edge t+1, visible with `f_valid`=1 after t+1. Penalty is 2 bubbles.
- DONE is entered on the edge after the last valid instruction leaves EX (`ex_valid` falls to 0 and the pipeline is empty).
- `busy`/`done` are registered from state and change on the same edge as the state.

## Structure
- Shared defines header: state encodings (`SEQ_IDLE`, `SEQ_LOAD`, `SEQ_RUN`, `SEQ_DONE`) and `PROG_DEPTH` default, alongside the existing opcode defines (`JNZ`, etc.).
- Sub-module `program_mem`: `PROG_DEPTH`×3 register store with one write port and two combinational read ports (`pc`, `pc+1`). Out-of-range reads return 0.
- FSM, program counter and valid pipeline live in `program_sequencer`.

## Test plan
- **Straight-line program**: load 0,3,5,4 (4 words), `start`. Expect `opcode`/`operand` = 0/3, then 5/4. Then `f_valid`=0, and `done`=1 exactly 3 cycles after the last fetch edge.
- **Taken jump**: load 5,4,3,0 and drive `jump_taken`=1, `jump_target`=0 when the JNZ has `ex_valid`. Expect all valids to clear, the next fetch to be 5/4, and no DONE.
- **Stall mid-run**: hold `stall_in` for 3 cycles while `f_valid`=1. Expect `pc`, `opcode` and valids frozen, `halt_id`=1, and a `jump_taken` asserted during the stall ignored.
- **Odd length and empty program**:
  - 3-word program: only one fetch, then DONE.
  - `prog_len`=0 with `start`: DONE 2 cycles after `start`.
- **Overflow load**: 20 words with `PROG_DEPTH`=16. Expect `prog_len`=16 and words 17–20 dropped.
- **Reset mid-RUN**: assert `rst` mid-RUN. Outputs return to reset values asynchronously with no clock edge, and `start` without reload gives immediate DONE.
